uart_tx_arbiter: RTL and testbench

Shares a single `uart_tx` transmitter between two byte-stream requesters (port 0: core, port 1: debug/monitor). Each requester writes bytes into its own small FIFO; a scheduler FSM drains the FIFOs in round-robin order, polling the transmitter busy flag over the `uart_tx` core protocol before each write. The block sits between the requesters and the `uart_tx` core-protocol port, and is the only master of that port.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_byte_fifo.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx arbiter.
package uart_pkg;

   localparam int unsigned UART_BYTE_W = 8;
   localparam int unsigned UART_BUS_W  = 32;

   localparam logic [UART_BUS_W-1:0] UART_DATA_ADDR   = 32'h0;
   localparam logic [UART_BUS_W-1:0] UART_STATUS_ADDR = 32'h8;
   localparam int unsigned           UART_BUSY_BIT    = 0;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_POLL,
      ARB_WRITE,
      ARB_WAIT
   } uart_arb_state_t;

   typedef struct packed {
      logic                  req;
      logic                  we;
      logic [UART_BUS_W-1:0] addr;
      logic [UART_BUS_W-1:0] wdata;
   } uart_bus_t;

   // Prefer the requester that was not served last; fall back to the other one.
   function automatic logic pick_grant(input logic last, input logic has0, input logic has1);
      if (last) begin
         return has0 ? 1'b0 : 1'b1;
      end
      return has1 ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with an extra pointer bit to tell full from empty.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push,
   input  logic                   pop,
   input  logic [UART_BYTE_W-1:0] din,
   output logic [UART_BYTE_W-1:0] dout,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]            wr_ptr;
   logic [AW:0]            rd_ptr;
   logic [UART_BYTE_W-1:0] mem [DEPTH];
   logic                   do_push;
   logic                   do_pop;

   // Full/empty come from registered pointers only, so a pop never frees a slot for the same-cycle push.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage carries no reset; only slots between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx core-protocol port between two byte requesters.
// Optional UART_ARB_BURST_EN lets a grant send up to BURST consecutive bytes.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned BURST = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   rq0_valid_i,
   input  logic [UART_BYTE_W-1:0] rq0_data_i,
   output logic                   rq0_ready_o,
   input  logic                   rq1_valid_i,
   input  logic [UART_BYTE_W-1:0] rq1_data_i,
   output logic                   rq1_ready_o,
   output logic                   tx_req_o,
   output logic                   tx_we_o,
   output logic [UART_BUS_W-1:0]  tx_addr_o,
   output logic [UART_BUS_W-1:0]  tx_wdata_o,
   input  logic [UART_BUS_W-1:0]  tx_rdata_i,
   output logic                   idle_o
);

   uart_arb_state_t        state_q, state_d;
   logic                   grant_q, grant_d;
   logic                   last_q, last_d;
   logic [1:0]             full;
   logic [1:0]             empty;
   logic [1:0]             pop;
   logic [UART_BYTE_W-1:0] head0, head1;
   uart_bus_t              bus_q, bus_d;

`ifdef UART_ARB_BURST_EN
   localparam int unsigned BW = $clog2(BURST + 1);
   logic [BW-1:0] cnt_q, cnt_d;
   logic          unused_rdata;
   assign unused_rdata = ^tx_rdata_i[UART_BUS_W-1:1];
`else
   logic unused_rdata;
   assign unused_rdata = ^{tx_rdata_i[UART_BUS_W-1:1], 32'(BURST)};
`endif

   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (rq0_valid_i),
      .pop   (pop[0]),
      .din   (rq0_data_i),
      .dout  (head0),
      .full  (full[0]),
      .empty (empty[0])
   );

   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (rq1_valid_i),
      .pop   (pop[1]),
      .din   (rq1_data_i),
      .dout  (head1),
      .full  (full[1]),
      .empty (empty[1])
   );

   assign rq0_ready_o = !full[0];
   assign rq1_ready_o = !full[1];
   assign idle_o      = (state_q == ARB_IDLE) && (&empty);

   assign tx_req_o   = bus_q.req;
   assign tx_we_o    = bus_q.we;
   assign tx_addr_o  = bus_q.addr;
   assign tx_wdata_o = bus_q.wdata;

   // State, grant and bus registers; the bus is registered from the next-state decode.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         bus_q   <= '0;
`ifdef UART_ARB_BURST_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         bus_q   <= bus_d;
`ifdef UART_ARB_BURST_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Scheduler next-state, pop and bus decode.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      pop     = '0;
      bus_d   = '0;
`ifdef UART_ARB_BURST_EN
      cnt_d   = cnt_q;
`endif

      case (state_q)
         ARB_IDLE: begin
            if (!(&empty)) begin
               grant_d = pick_grant(last_q, !empty[0], !empty[1]);
               state_d = ARB_POLL;
`ifdef UART_ARB_BURST_EN
               cnt_d   = '0;
`endif
            end
         end
         ARB_POLL: begin
            if (!tx_rdata_i[UART_BUSY_BIT]) state_d = ARB_WRITE;
         end
         ARB_WRITE: begin
            pop[0]  = !grant_q;
            pop[1]  = grant_q;
            last_d  = grant_q;
            state_d = ARB_WAIT;
`ifdef UART_ARB_BURST_EN
            cnt_d   = cnt_q + BW'(1);
`endif
         end
         ARB_WAIT: begin
            state_d = ARB_IDLE;
`ifdef UART_ARB_BURST_EN
            if (!empty[grant_q] && (cnt_q < BW'(BURST))) state_d = ARB_POLL;
`endif
         end
         default: state_d = ARB_IDLE;
      endcase

      case (state_d)
         ARB_POLL: begin
            bus_d.req  = 1'b1;
            bus_d.addr = UART_STATUS_ADDR;
         end
         ARB_WRITE: begin
            bus_d.req   = 1'b1;
            bus_d.we    = 1'b1;
            bus_d.addr  = UART_DATA_ADDR;
            bus_d.wdata = UART_BUS_W'(grant_d ? head1 : head0);
         end
         default: bus_d = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected write bytes queued at stimulus, checked by a bus monitor.
module tb_uart_tx_arbiter;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned BURST = 2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        rq0_valid_i = 1'b0;
   logic [7:0]  rq0_data_i = 8'h0;
   logic        rq0_ready_o;
   logic        rq1_valid_i = 1'b0;
   logic [7:0]  rq1_data_i = 8'h0;
   logic        rq1_ready_o;
   logic        tx_req_o;
   logic        tx_we_o;
   logic [31:0] tx_addr_o;
   logic [31:0] tx_wdata_o;
   logic [31:0] tx_rdata_i;
   logic        idle_o;

   logic        busy = 1'b0;
   logic        acc;
   int          checks = 0;
   int          passed = 0;
   int          writes = 0;
   logic [7:0]  sb [$];

   uart_tx_arbiter #(.DEPTH(DEPTH), .BURST(BURST)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rq0_valid_i (rq0_valid_i),
      .rq0_data_i  (rq0_data_i),
      .rq0_ready_o (rq0_ready_o),
      .rq1_valid_i (rq1_valid_i),
      .rq1_data_i  (rq1_data_i),
      .rq1_ready_o (rq1_ready_o),
      .tx_req_o    (tx_req_o),
      .tx_we_o     (tx_we_o),
      .tx_addr_o   (tx_addr_o),
      .tx_wdata_o  (tx_wdata_o),
      .tx_rdata_i  (tx_rdata_i),
      .idle_o      (idle_o)
   );

   always #5 clk_i = ~clk_i;

   // Transmitter model: busy flag visible only on a status read.
   assign tx_rdata_i = (tx_req_o && !tx_we_o && tx_addr_o == 32'h8) ? {31'b0, busy} : 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every bus cycle is checked; writes are matched against the scoreboard.
   always @(negedge clk_i) begin
      if (!rst_i && tx_req_o) begin
         if (tx_we_o) begin
            writes++;
            check("write_addr", tx_addr_o, 32'h0);
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_write: got %h expected no write", tx_wdata_o);
            end else begin
               check("write_data", tx_wdata_o, {24'h0, sb.pop_front()});
            end
         end else begin
            check("poll_addr", tx_addr_o, 32'h8);
         end
      end
   end

   task automatic push(input int port, input logic [7:0] d, output logic ok);
      @(negedge clk_i);
      if (port == 0) begin
         rq0_valid_i = 1'b1;
         rq0_data_i  = d;
         ok          = rq0_ready_o;
      end else begin
         rq1_valid_i = 1'b1;
         rq1_data_i  = d;
         ok          = rq1_ready_o;
      end
      @(posedge clk_i);
      #1;
      rq0_valid_i = 1'b0;
      rq1_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || !idle_o) && n < 2000) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check(name, 32'((sb.size() != 0) || !idle_o), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int w0;
      logic [7:0] d;

      // Reset state
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_req", 32'(tx_req_o), 32'h0);
      check("rst_we", 32'(tx_we_o), 32'h0);
      check("rst_addr", tx_addr_o, 32'h0);
      check("rst_wdata", tx_wdata_o, 32'h0);
      check("rst_ready0", 32'(rq0_ready_o), 32'h1);
      check("rst_ready1", 32'(rq1_ready_o), 32'h1);
      check("rst_idle", 32'(idle_o), 32'h1);

      // Single byte, transmitter idle: WRITE two edges after the push edge
      busy = 1'b0;
      sb.push_back(8'hA5);
      push(0, 8'hA5, acc);
      check("single_ready", 32'(acc), 32'h1);
      n = 0;
      do begin
         @(posedge clk_i);
         #1;
         n++;
      end while (!tx_we_o && n < 10);
      check("single_latency", 32'(n), 32'd2);
      check("single_wdata", tx_wdata_o, 32'hA5);
      wait_drain("single_drain");
      check("single_idle", 32'(idle_o), 32'h1);
      check("single_req_low", 32'(tx_req_o), 32'h0);

      // Busy hold: POLL persists while busy, exactly one write afterwards
      busy = 1'b1;
      w0 = writes;
      sb.push_back(8'h5A);
      push(1, 8'h5A, acc);
      repeat (20) @(posedge clk_i);
      #1;
      check("busy_no_write", 32'(writes), 32'(w0));
      check("busy_polling", 32'(tx_req_o && !tx_we_o), 32'h1);
      busy = 1'b0;
      wait_drain("busy_drain");
      check("busy_one_write", 32'(writes), 32'(w0 + 1));

      // Async reset between edges during WRITE
      push(0, 8'h77, acc);
      n = 0;
      while (!tx_we_o && n < 10) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check("arst_in_write", 32'(tx_we_o), 32'h1);
      #1;
      rst_i = 1'b1;
      #1;
      check("arst_req", 32'(tx_req_o), 32'h0);
      check("arst_we", 32'(tx_we_o), 32'h0);
      check("arst_addr", tx_addr_o, 32'h0);
      check("arst_wdata", tx_wdata_o, 32'h0);
      check("arst_idle", 32'(idle_o), 32'h1);
      check("arst_ready0", 32'(rq0_ready_o), 32'h1);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Fairness after reset: port 0 wins the first tie
      busy = 1'b1;
`ifdef UART_ARB_BURST_EN
      sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h11);
      sb.push_back(8'h12); sb.push_back(8'h03); sb.push_back(8'h13);
`else
      sb.push_back(8'h01); sb.push_back(8'h11); sb.push_back(8'h02);
      sb.push_back(8'h12); sb.push_back(8'h03); sb.push_back(8'h13);
`endif
      for (int i = 0; i < 3; i++) push(0, 8'(8'h01 + i), acc);
      for (int i = 0; i < 3; i++) push(1, 8'(8'h11 + i), acc);
      busy = 1'b0;
      wait_drain("fair_drain");

      // Full FIFO on port 1: DEPTH accepted, the extra one rejected
      busy = 1'b1;
      for (int i = 0; i <= int'(DEPTH); i++) begin
         d = 8'(8'hB0 + i);
         push(1, d, acc);
         check("full_ready", 32'(acc), (i < int'(DEPTH)) ? 32'h1 : 32'h0);
         if (i < int'(DEPTH)) sb.push_back(d);
      end
      busy = 1'b0;
      wait_drain("full_drain");
      repeat (8) @(posedge clk_i);
      #1;
      check("full_ready_back", 32'(rq1_ready_o), 32'h1);
      check("full_idle", 32'(idle_o), 32'h1);

      do_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
